// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types, defaults and index stepping for the line scan sequencer
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_CNT_W  = 8;

  // Steps toward last, wrapping to first; never leaves [min(first,last), max(first,last)].
  function automatic int unsigned next_idx(input int unsigned x,
                                           input int unsigned first,
                                           input int unsigned last);
    if (x == last)
      return first;
    else if (first <= last)
      return x + 1;
    else
      return x - 1;
  endfunction

endpackage

// File: rtl/scan_down_cnt.sv
// rtl/scan_down_cnt.sv - loadable down-counter shared by the dwell and gap phases
module scan_down_cnt
  import scan_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/scan_addr_seq.sv
// rtl/scan_addr_seq.sv - steps the decoder line index through a range with dwell and blanking gap
module scan_addr_seq
  import scan_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] first,
  input  logic [ADDR_W-1:0] last,
  input  logic [CNT_W-1:0]  dwell,
  input  logic [CNT_W-1:0]  gap,
  input  logic              cont,
  output logic [ADDR_W-1:0] x,
  output logic              en,
  output logic              busy,
  output logic              line_done,
  output logic              scan_done
);

  scan_state_t       r_state;
  logic [ADDR_W-1:0] r_first_s;
  logic [ADDR_W-1:0] r_last_s;
  logic [CNT_W-1:0]  r_dwell_s;
  logic [CNT_W-1:0]  r_gap_s;
  logic              r_cont_s;
  logic              r_stop_pend;
  logic [ADDR_W-1:0] r_x;
  logic              r_en;
  logic              r_busy;

  logic              w_cnt_zero;
  logic              w_cnt_load;
  logic [CNT_W-1:0]  w_cnt_load_val;
  logic              w_cnt_dec;
  logic              w_stop_eff;
  logic              w_line_end;
  logic              w_scan_end;
  logic [ADDR_W-1:0] w_next_x;

  // A zero dwell still enables the line for one cycle.
  function automatic logic [CNT_W-1:0] dwell_m1(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  scan_down_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // A stop arriving on the deciding cycle itself counts as pending.
  always_comb begin
    w_stop_eff = r_stop_pend | stop;
    w_next_x   = ADDR_W'(next_idx(32'(r_x), 32'(r_first_s), 32'(r_last_s)));
    w_line_end = (r_state == ON) && w_cnt_zero;
    w_scan_end = w_line_end && (w_stop_eff || ((r_x == r_last_s) && !r_cont_s));
  end

  always_comb begin
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_dec      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          w_cnt_load     = 1'b1;
          w_cnt_load_val = dwell_m1(dwell);
        end
      end
      ON: begin
        if (!w_cnt_zero) begin
          w_cnt_dec = 1'b1;
        end else if (!w_scan_end) begin
          w_cnt_load     = 1'b1;
          w_cnt_load_val = (r_gap_s == '0) ? dwell_m1(r_dwell_s) : r_gap_s - 1'b1;
        end
      end
      GAP: begin
        if (!w_cnt_zero) begin
          w_cnt_dec = 1'b1;
        end else if (!w_stop_eff) begin
          w_cnt_load     = 1'b1;
          w_cnt_load_val = dwell_m1(r_dwell_s);
        end
      end
      default: begin
        w_cnt_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_first_s   <= '0;
      r_last_s    <= '0;
      r_dwell_s   <= '0;
      r_gap_s     <= '0;
      r_cont_s    <= 1'b0;
      r_stop_pend <= 1'b0;
      r_x         <= '0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_stop_pend <= 1'b0;
          if (start && !stop) begin
            r_first_s <= first;
            r_last_s  <= last;
            r_dwell_s <= dwell;
            r_gap_s   <= gap;
            r_cont_s  <= cont;
            r_x       <= first;
            r_en      <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ON;
          end
        end
        ON: begin
          if (stop) r_stop_pend <= 1'b1;
          if (w_cnt_zero) begin
            if (w_scan_end) begin
              r_state     <= IDLE;
              r_en        <= 1'b0;
              r_busy      <= 1'b0;
              r_stop_pend <= 1'b0;
            end else if (r_gap_s == '0) begin
              r_x <= w_next_x;
            end else begin
              r_state <= GAP;
              r_en    <= 1'b0;
            end
          end
        end
        GAP: begin
          if (stop) r_stop_pend <= 1'b1;
          if (w_cnt_zero) begin
            if (w_stop_eff) begin
              r_state     <= IDLE;
              r_busy      <= 1'b0;
              r_stop_pend <= 1'b0;
            end else begin
              r_state <= ON;
              r_en    <= 1'b1;
              r_x     <= w_next_x;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign x         = r_x;
  assign en        = r_en;
  assign busy      = r_busy;
  assign line_done = w_line_end;
  assign scan_done = w_scan_end;

endmodule

// File: tb/tb_scan_addr_seq.sv
// tb/tb_scan_addr_seq.sv - scoreboard bench for scan_addr_seq against a line-list reference model
module tb_scan_addr_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [5:0] first = '0;
  logic [5:0] last = '0;
  logic [7:0] dwell = '0;
  logic [7:0] gap = '0;
  logic       cont = 1'b0;
  logic [5:0] x;
  logic       en;
  logic       busy;
  logic       line_done;
  logic       scan_done;

  typedef struct packed {
    logic [5:0] x;
    logic       ld;
    logic       sd;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  scan_addr_seq #(
    .ADDR_W (6),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .first     (first),
    .last      (last),
    .dwell     (dwell),
    .gap       (gap),
    .cont      (cont),
    .x         (x),
    .en        (en),
    .busy      (busy),
    .line_done (line_done),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every en-high cycle must match the next expected line cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (en) begin
        if (q.size() == 0) begin
          check("unexpected_en", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("x", int'(x), int'(e.x));
          check("line_done", int'(line_done), int'(e.ld));
          check("scan_done", int'(scan_done), int'(e.sd));
        end
      end else if (line_done || scan_done) begin
        check("pulse_without_en", int'({line_done, scan_done}), 0);
      end
    end
  end

  // Reference: the list of lines in visit order, walked cyclically; each visit is d en-cycles.
  task automatic build_model(input int f, input int l, input int dw, input int g,
                             input int k, input bit in_gap, output int busy_exp);
    int   seq[$];
    int   d, n, nv;
    exp_t e;
    if (f <= l) for (int i = f; i <= l; i++) seq.push_back(i);
    else        for (int i = f; i >= l; i--) seq.push_back(i);
    n  = seq.size();
    d  = (dw == 0) ? 1 : dw;
    nv = (k >= 0) ? k + 1 : n;
    for (int v = 0; v < nv; v++) begin
      for (int c = 0; c < d; c++) begin
        e.x  = 6'(seq[v % n]);
        e.ld = (c == d - 1);
        e.sd = (c == d - 1) && (v == nv - 1) && !in_gap;
        q.push_back(e);
      end
    end
    busy_exp = in_gap ? nv * (d + g) : nv * d + (nv - 1) * g;
  endtask

  // k = visit index during which stop is raised (-1: none); in_gap moves it into the following gap.
  task automatic run_scan(input string name, input int f, input int l, input int dw,
                          input int g, input bit cn, input int k, input bit in_gap,
                          input bit scramble);
    int busy_exp, stop_edge, busy_cnt, e, d;
    build_model(f, l, dw, g, k, in_gap, busy_exp);
    d = (dw == 0) ? 1 : dw;
    stop_edge = (k < 0) ? -1 : (in_gap ? k * (d + g) + d : k * (d + g));
    @(negedge clk);
    first = 6'(f); last = 6'(l); dwell = 8'(dw); gap = 8'(g); cont = cn;
    start = 1'b1; stop = 1'b0;
    e = 0; busy_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy) break;
      busy_cnt++;
      start = (e == 0);
      stop  = (e == stop_edge);
      if (scramble && e == 0) begin
        first = 6'($urandom); last = 6'($urandom);
        dwell = 8'($urandom); gap = 8'($urandom); cont = 1'($urandom);
      end
      e++;
      if (e > 5000) begin
        check({name, "_timeout"}, e, 0);
        break;
      end
    end
    start = 1'b0; stop = 1'b0;
    check({name, "_busy_cycles"}, busy_cnt, busy_exp);
    repeat (2) @(negedge clk);
    check({name, "_queue_left"}, q.size(), 0);
    check({name, "_en_idle"}, int'(en), 0);
    q.delete();
  endtask

  initial begin
    int dummy;
    #1;
    check("rst_x", int'(x), 0);
    check("rst_en", int'(en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_line_done", int'(line_done), 0);
    check("rst_scan_done", int'(scan_done), 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    run_scan("basic", 2, 5, 3, 0, 1'b0, -1, 1'b0, 1'b0);
    run_scan("gap_desc", 10, 8, 1, 2, 1'b0, -1, 1'b0, 1'b0);
    run_scan("wrap_stop", 62, 63, 2, 0, 1'b1, 2, 1'b0, 1'b0);
    run_scan("dwell0_single", 0, 0, 0, 0, 1'b0, -1, 1'b0, 1'b0);
    run_scan("stop_in_gap", 5, 9, 2, 3, 1'b1, 1, 1'b1, 1'b0);
    run_scan("single_cont", 7, 7, 2, 1, 1'b1, 3, 1'b0, 1'b0);
    run_scan("stable_inputs", 20, 17, 2, 1, 1'b0, -1, 1'b0, 1'b1);

    // start and stop together in IDLE: stop wins
    @(negedge clk);
    first = 6'd3; last = 6'd4; dwell = 8'd1; gap = 8'd0; cont = 1'b0;
    start = 1'b1; stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("start_stop_en", int'(en), 0);

    // asynchronous reset mid-line
    @(negedge clk);
    build_model(2, 5, 3, 0, -1, 1'b0, dummy);
    first = 6'd2; last = 6'd5; dwell = 8'd3; gap = 8'd0; cont = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_en", int'(en), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_x", int'(x), 0);
    check("arst_line_done", int'(line_done), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_scan("after_reset", 2, 5, 3, 0, 1'b0, -1, 1'b0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      int f, l, dw, g, n, k;
      bit cn, ig;
      f  = $urandom_range(0, 63);
      l  = $urandom_range(0, 63);
      dw = $urandom_range(0, 4);
      g  = $urandom_range(0, 3);
      cn = 1'($urandom);
      n  = (f <= l) ? l - f + 1 : f - l + 1;
      ig = 1'b0;
      if (cn) begin
        k = $urandom_range(0, n + 2);
      end else if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, n - 1);
      end else begin
        k = -1;
      end
      if (k >= 0 && g > 0 && $urandom_range(0, 1) == 1 && (cn || k < n - 1)) ig = 1'b1;
      run_scan($sformatf("rand%0d", t), f, l, dw, g, cn, k, ig, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
